aes128_round_key_gen: RTL and testbench

Iterative AES-128 key schedule that expands a 128-bit cipher key into round keys 0..NUM_ROUNDS, one full round key per accepted handshake. Instantiates four sBox lookups for SubWord of the last word. Sits upstream of the round datapath and feeds it round keys over a valid/ready stream.

---
 rtl/aes128_round_key_gen.sv | 158 +++++++++++++++
 tb/tb_aes128_round_key_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/aes128_round_key_gen.sv
`default_nettype none
// ============================================================================
// aes128_round_key_gen : iterative AES-128 key expansion, one round key per
// valid/ready handshake.                                         Rev 1.0
// ============================================================================

module aes128_sbox (
    input  logic [7:0] data,
    output logic [7:0] subst
);
    localparam logic [0:255][7:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign subst = C_SBOX[data];
endmodule

module aes128_round_key_gen #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);
    localparam logic [3:0] C_LAST = 4'(NUM_ROUNDS);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [127:0] w_rk_next;
    logic [3:0]   w_idx_next;
    logic         w_valid_next;
    logic         w_busy_next;
    logic         w_done_next;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot, w_sub, w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [3:0]   w_idx_inc;
    logic [7:0]   w_rcon;

    assign {w_w0, w_w1, w_w2, w_w3} = rk_out;
    assign w_idx_inc = rk_idx + 4'd1;
    assign w_rot     = {w_w3[23:0], w_w3[31:24]};

    generate
        for (genvar g = 0; g < 4; g++) begin : g_sbox
            aes128_sbox u_sbox (
                .data  (w_rot[8*g +: 8]),
                .subst (w_sub[8*g +: 8])
            );
        end
    endgenerate

    always_comb begin
        w_rcon = 8'h00;
        case (w_idx_inc)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // Word chain: each new word depends on the one just produced.
    assign w_t  = w_sub ^ {w_rcon, 24'h000000};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    always_comb begin
        w_state_next = r_state;
        w_rk_next    = rk_out;
        w_idx_next   = rk_idx;
        w_valid_next = rk_valid;
        w_busy_next  = busy;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_rk_next    = key_in;
                    w_idx_next   = 4'd0;
                    w_valid_next = 1'b1;
                    w_busy_next  = 1'b1;
                    w_state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                if (rk_valid && rk_ready) begin
                    if (rk_idx == C_LAST) begin
                        w_valid_next = 1'b0;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_rk_next  = {w_n0, w_n1, w_n2, w_n3};
                        w_idx_next = w_idx_inc;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            rk_out   <= 128'h0;
            rk_idx   <= 4'd0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            rk_out   <= w_rk_next;
            rk_idx   <= w_idx_next;
            rk_valid <= w_valid_next;
            busy     <= w_busy_next;
            done     <= w_done_next;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_aes128_round_key_gen.sv
`default_nettype none
// ============================================================================
// tb_aes128_round_key_gen : directed self-checking bench for the key schedule.
//                                                                 Rev 1.0
// ============================================================================

module tb_aes128_round_key_gen;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] fips_rk [0:10];
    localparam logic [127:0] C_FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    aes128_round_key_gen #(.NUM_ROUNDS(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        int           exp_idx;
        int           stall3;
        logic         rdy;
        logic         prev_stall;
        logic [127:0] prev_rk;
        logic [3:0]   prev_idx;

        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst = 1'b1; start = 1'b0; key_in = '0; rk_ready = 1'b0;
        step(); step();
        chk("reset_rk", rk_out, 128'h0);
        chk("reset_ctl", {124'h0, rk_idx, rk_valid, busy, done} >> 3, 128'h0);
        chk("reset_flags", {125'h0, rk_valid, busy, done}, 128'h0);
        rst = 1'b0;

        // Idle with no start: everything stays at zero.
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("idle_rk_%0d", i), rk_out, 128'h0);
            chk($sformatf("idle_ctl_%0d", i), {121'h0, rk_idx, rk_valid, busy, done}, 128'h0);
        end

        // rst and start together: reset wins.
        rst = 1'b1; start = 1'b1; key_in = C_FIPS_KEY;
        step();
        rst = 1'b0; start = 1'b0;
        chk("rst_start_valid", {127'h0, rk_valid}, 128'h0);
        step();
        chk("rst_start_after", {126'h0, rk_valid, busy}, 128'h0);

        // Back-to-back expansion of the FIPS-197 key.
        key_in = C_FIPS_KEY; start = 1'b1; rk_ready = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            chk($sformatf("s1_rk%0d", i), rk_out, fips_rk[i]);
            chk($sformatf("s1_idx%0d", i), {124'h0, rk_idx}, 128'(i));
            chk($sformatf("s1_flags%0d", i), {125'h0, rk_valid, busy, done}, 128'b110);
            if (i < 10) step();
        end
        step();
        chk("s1_done", {125'h0, rk_valid, busy, done}, 128'b001);
        step();
        chk("s1_done_drop", {127'h0, done}, 128'h0);

        // Backpressure with a forced five-cycle stall on idx 3.
        rk_ready = 1'b0; key_in = C_FIPS_KEY; start = 1'b1;
        step();
        start = 1'b0;
        exp_idx = 0; stall3 = 0; prev_stall = 1'b0; prev_rk = '0; prev_idx = '0;
        for (int cyc = 0; cyc < 300 && exp_idx < 11; cyc++) begin
            if (prev_stall) begin
                chk("s2_stable_rk", rk_out, prev_rk);
                chk("s2_stable_idx", {124'h0, rk_idx}, {124'h0, prev_idx});
            end
            chk("s2_valid", {127'h0, rk_valid}, 128'h1);
            if (rk_idx == 4'd3 && stall3 < 5) begin
                rdy = 1'b0;
                stall3++;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            rk_ready = rdy;
            if (rdy) begin
                chk($sformatf("s2_idx%0d", exp_idx), {124'h0, rk_idx}, 128'(exp_idx));
                chk($sformatf("s2_rk%0d", exp_idx), rk_out, fips_rk[exp_idx]);
                exp_idx++;
            end
            prev_stall = !rdy; prev_rk = rk_out; prev_idx = rk_idx;
            step();
        end
        chk("s2_all_keys_seen", 128'(exp_idx), 128'd11);
        chk("s2_stall3_len", 128'(stall3), 128'd5);
        chk("s2_done", {125'h0, rk_valid, busy, done}, 128'b001);
        rk_ready = 1'b1;
        step();

        // Reset in the middle of an expansion.
        key_in = C_FIPS_KEY; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("s3_at_idx5", {124'h0, rk_idx}, 128'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s3_rst_rk", rk_out, 128'h0);
        chk("s3_rst_ctl", {121'h0, rk_idx, rk_valid, busy, done}, 128'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("s3_quiet%0d", i), {125'h0, rk_valid, busy, done}, 128'h0);
        end
        key_in = C_SEQ_KEY; start = 1'b1;
        step();
        start = 1'b0;
        chk("s3_rk0", rk_out, C_SEQ_KEY);
        repeat (10) step();
        chk("s3_idx10", {124'h0, rk_idx}, 128'd10);
        chk("s3_rk10", rk_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        step();
        chk("s3_done", {125'h0, rk_valid, busy, done}, 128'b001);
        step();

        // start during EMIT with another key is ignored.
        key_in = C_FIPS_KEY; start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        key_in = {128{1'b1}}; start = 1'b1;
        step();
        start = 1'b0;
        chk("s4_idx3", {124'h0, rk_idx}, 128'd3);
        chk("s4_rk3", rk_out, fips_rk[3]);
        repeat (7) step();
        chk("s4_rk10", rk_out, fips_rk[10]);
        step();
        chk("s4_done", {125'h0, rk_valid, busy, done}, 128'b001);

        // start in the done cycle with an all-zero key.
        key_in = 128'h0; start = 1'b1;
        step();
        start = 1'b0;
        chk("s5_flags0", {125'h0, rk_valid, busy, done}, 128'b110);
        chk("s5_idx0", {124'h0, rk_idx}, 128'd0);
        chk("s5_rk0", rk_out, 128'h0);
        step();
        chk("s5_idx1", {124'h0, rk_idx}, 128'd1);
        chk("s5_rk1", rk_out, 128'h62636363626363636263636362636363);
        repeat (9) step();
        chk("s5_idx10", {124'h0, rk_idx}, 128'd10);
        step();
        chk("s5_done", {125'h0, rk_valid, busy, done}, 128'b001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
